// File: rtl/aes_axil_ctrl.sv
// AXI4-Lite register front end for the AES core: key/data/result registers,
// start/busy/done control and a level interrupt.
module aes_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    core_key,
  output logic [127:0]                    core_din,
  output logic                            core_decrypt,
  output logic                            core_start,
  input  logic                            core_done,
  input  logic [127:0]                    core_dout,
  output logic                            irq
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] key_q [4];
  logic [31:0] din_q [4];
  logic [31:0] dout_q [4];
  logic        mode_q, ie_q, done_q, start_q, decrypt_q, irq_q;
  logic        wr_hs, rd_hs;
  logic [3:0]  aw_idx, ar_idx;

  // Protection bits and byte offsets carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_idx = S_AXI_AWADDR[5:2];
  assign ar_idx = S_AXI_ARADDR[5:2];
  assign wr_hs  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = arready_q & S_AXI_ARVALID;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  // Operands are plain register views; busy blocks writes so they stay stable.
  assign core_key      = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign core_din      = {din_q[0], din_q[1], din_q[2], din_q[3]};
  assign core_decrypt  = decrypt_q;
  assign core_start    = start_q;
  assign irq           = irq_q;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Write channel: accept AW+W together, one outstanding response at a time.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      if (wr_hs)             bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end

  // Read mux, evaluated against register state in the ARREADY cycle.
  always_comb begin
    rdata_d = '0;
    case (ar_idx[3:2])
      2'b00: begin
        if (ar_idx[1:0] == 2'd0) rdata_d = {29'b0, ie_q, mode_q, 1'b0};
        if (ar_idx[1:0] == 2'd1) rdata_d = {30'b0, done_q, state_q == RUN};
      end
      2'b01:   rdata_d = key_q[ar_idx[1:0]];
      2'b10:   rdata_d = din_q[ar_idx[1:0]];
      default: rdata_d = dout_q[ar_idx[1:0]];
    endcase
  end

  // Read channel: one ARREADY pulse, data held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register file and IDLE/RUN control; a core_done set of done overrides a same-cycle W1C.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      decrypt_q <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      start_q <= 1'b0;
      irq_q   <= done_q & ie_q;
      if (wr_hs) begin
        if (aw_idx == 4'd0 && S_AXI_WSTRB[0]) begin
          ie_q <= S_AXI_WDATA[2];
          if (state_q == IDLE) begin
            mode_q <= S_AXI_WDATA[1];
            if (S_AXI_WDATA[0]) begin
              start_q   <= 1'b1;
              decrypt_q <= S_AXI_WDATA[1];
              done_q    <= 1'b0;
              state_q   <= RUN;
            end
          end
        end
        if (aw_idx == 4'd1 && S_AXI_WSTRB[0] && S_AXI_WDATA[1]) done_q <= 1'b0;
        if (state_q == IDLE && aw_idx[3:2] == 2'b01)
          key_q[aw_idx[1:0]] <= merge(key_q[aw_idx[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
        if (state_q == IDLE && aw_idx[3:2] == 2'b10)
          din_q[aw_idx[1:0]] <= merge(din_q[aw_idx[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
      end
      if (state_q == RUN && core_done) begin
        for (int i = 0; i < 4; i++) dout_q[i] <= core_dout[127-32*i -: 32];
        done_q  <= 1'b1;
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: doc/aes_axil_ctrl.md
# aes_axil_ctrl

AXI4-Lite slave register front end for the AES RTL core. It sits directly downstream of the PS/VIP AXI4-Lite master and directly upstream of the AES datapath. It holds a 128-bit key and a 128-bit input block written by software, launches one core operation per start command, and captures the 128-bit result for readback. Status is visible by polling and through a level interrupt.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width. The register map covers 16 words.
- ACLK in 1: sole clock.
- ARESETN in 1: asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out: AXI4-Lite write address channel. AWPROT is ignored.
- S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in, S_AXI_WREADY out: write data channel.
- S_AXI_BRESP out 2, S_AXI_BVALID out, S_AXI_BREADY in: write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out: read address channel.
- S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out, S_AXI_RREADY in: read data channel.
- core_key out 128, core_din out 128: operands. They are held stable from core_start until core_done.
- core_decrypt out 1: CTRL.mode, latched at start.
- core_start out 1: one-cycle launch pulse.
- core_done in 1: one-cycle result-valid pulse.
- core_dout in 128: result, sampled on core_done.
- irq out 1: level interrupt, equal to STATUS.done & CTRL.ie.

## Operation
Register map:
- 0x00 CTRL:
  - bit0 start: write 1 to launch; reads 0.
  - bit1 mode: 1 = decrypt.
  - bit2 ie: interrupt enable.
- 0x04 STATUS:
  - bit0 busy: read-only.
  - bit1 done: sticky; write 1 to clear.
- 0x10–0x1C KEY0..3. KEY0 = key[127:96].
- 0x20–0x2C DIN0..3. DIN0 = din[127:96].
- 0x30–0x3C DOUT0..3: read-only. DOUT0 = dout[127:96].
- All other addresses: reads return 0, writes are ignored. Every response is OKAY (2'b00).

Write and strobe rules:
- WSTRB applies per byte to KEY and DIN.
- CTRL and STATUS act only when WSTRB[0]=1.
- Writes to KEY, DIN or CTRL.mode while busy are dropped. They still receive OKAY.

FSM:
- IDLE: a CTRL write with bit0=1 asserts core_start for 1 cycle, clears done, sets busy, and moves to RUN.
- RUN: a start request is ignored. core_done captures core_dout into DOUT, clears busy, sets done, and moves to IDLE.
- core_done while in IDLE is ignored.
- When core_done arrives in the same cycle as a W1C of STATUS.done, done ends set (the set wins).
- Reset at any point: returns the FSM to IDLE with all registers zero. An operation in flight is abandoned, and a late core_done is ignored.

## Timing
Reset values:
- AWREADY, WREADY, BVALID, ARREADY, RVALID, core_start, irq: 0.
- RDATA, BRESP, RRESP, core_key, core_din, core_decrypt: 0.
- Registers: all 0.

Write handshake:
- The write is accepted only when AWVALID & WVALID & !BVALID.
- AWREADY and WREADY pulse high together for exactly 1 cycle.
- Register update takes effect in the acceptance cycle +1.
- BVALID rises in the acceptance cycle +1 and holds until BREADY.
- At most one write is outstanding. An AW arriving without W, or W without AW, waits without being accepted.

Read handshake:
- ARREADY pulses for 1 cycle when ARVALID & !RVALID.
- RVALID and RDATA appear in the following cycle. RDATA holds until RREADY.
- RDATA reflects register state at the ARREADY cycle.

Core timing:
- core_start is asserted in the cycle after the CTRL write acceptance, together with busy=1.
- DOUT and done update in the cycle after core_done.
- irq follows done and ie with 1 cycle of register latency.
- Reads and writes are handled concurrently and independently.

## Test plan
- Reset: after ARESETN=0 with no other stimulus, all outputs are 0. Reading 0x04 returns 0x0.
- Register round-trip: write 0x00000001–0x00000004 to 0x10–0x1C, then read back the same values. Write 0xAABBCCDD with WSTRB=4'b0101 to 0x20; it reads back 0x00BB00DD.
- FIPS-197 encrypt, using a 12-cycle behavioural core model:
  - Set KEY = 000102..0F and DIN = 00112233..FF, then write CTRL=0x5.
  - Exactly 1 core_start pulse occurs.
  - STATUS reads 0x1 while the operation runs.
  - Afterwards, DOUT reads 69C4E0D8 6A7B0430 D8CDB780 70B4C55A, STATUS reads 0x2, and irq=1.
  - Writing STATUS=0x2 makes irq drop to 0.
- Busy protection: write KEY0=0xFFFFFFFF and CTRL=0x1 during RUN. KEY0 is unchanged, no second core_start occurs, and both writes return BRESP=0.
- Handshake stress:
  - AWVALID is presented 5 cycles before WVALID; acceptance happens only once both are high.
  - BREADY is held low for 10 cycles; BVALID stays 1 and no new write is accepted.
  - An unmapped read of 0x3C+4 wraps to 0x00 and returns CTRL.
- Reset mid-operation: assert ARESETN low during RUN, then deliver core_done after release. STATUS stays 0 and DOUT stays 0.
